// File: rtl/common_pkg.sv
// Shared sizing constants and FSM state encoding for the clause-store SAT solver.
package common;
  localparam int number_literal = 30;
  localparam int number_clause  = 64;
  localparam int CNT_W   = $clog2(number_clause + 1);
  localparam int IDX_W   = $clog2(number_clause);
  localparam int DEPTH_W = $clog2(number_literal + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEARCH,
    BACKTRACK,
    DONE
  } state_t;
endpackage

// File: rtl/clause_check.sv
// Flags a conflict when any stored clause has every literal assigned and false.
module clause_check import common::*; (
  input  logic [number_literal-1:0] pos [number_clause],
  input  logic [number_literal-1:0] neg [number_clause],
  input  logic [CNT_W-1:0]          count,
  input  logic [number_literal-1:0] assigned,
  input  logic [number_literal-1:0] value,
  output logic                      conflict
);
  logic [number_literal-1:0] pos_false;
  logic [number_literal-1:0] neg_false;

  // A literal counts as false only once its variable is assigned.
  assign pos_false = assigned & ~value;
  assign neg_false = assigned & value;

  always_comb begin
    conflict = 1'b0;
    for (int c = 0; c < number_clause; c++) begin
      if ((CNT_W'(c) < count) &&
          ((pos[c] & ~pos_false) == '0) &&
          ((neg[c] & ~neg_false) == '0)) begin
        conflict = 1'b1;
      end
    end
  end
endmodule

// File: rtl/top.sv
// Streams clauses into a store, then runs a chronological-backtracking search
// in variable order, reporting the lexicographically smallest model.
module top import common::*; (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [number_literal-1:0] i,
  output logic                      ended,
  output logic                      sat,
  output logic [number_literal-1:0] model
);
  state_t                    state_q, state_d;
  logic [number_literal-1:0] pos_q [number_clause];
  logic [number_literal-1:0] pos_d [number_clause];
  logic [number_literal-1:0] neg_q [number_clause];
  logic [number_literal-1:0] neg_d [number_clause];
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      half_q, half_d;
  logic [number_literal-1:0] assigned_q, assigned_d;
  logic [number_literal-1:0] value_q, value_d;
  logic [number_literal-1:0] tried1_q, tried1_d;
  logic [DEPTH_W-1:0]        depth_q, depth_d;
  logic                      ended_q, ended_d;
  logic                      sat_q, sat_d;
  logic [number_literal-1:0] model_q, model_d;

  logic                      conflict;
  logic [IDX_W-1:0]          slot;
  logic [DEPTH_W-1:0]        next_bit;
  logic [DEPTH_W-1:0]        last_bit;

  clause_check u_check (
    .pos      (pos_q),
    .neg      (neg_q),
    .count    (count_q),
    .assigned (assigned_q),
    .value    (value_q),
    .conflict (conflict)
  );

  assign slot = count_q[IDX_W-1:0];
  // Variable k lives at bit number_literal-1-k, so the MSB is variable 0.
  assign next_bit = DEPTH_W'(number_literal - 1) - depth_q;
  assign last_bit = DEPTH_W'(number_literal) - depth_q;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    neg_d      = neg_q;
    count_d    = count_q;
    half_d     = half_q;
    assigned_d = assigned_q;
    value_d    = value_q;
    tried1_d   = tried1_q;
    depth_d    = depth_q;
    ended_d    = ended_q;
    sat_d      = sat_q;
    model_d    = model_q;

    case (state_q)
      IDLE, LOAD: begin
        if (load) begin
          state_d = LOAD;
          half_d  = ~half_q;
          if (count_q < CNT_W'(number_clause)) begin
            if (!half_q) begin
              pos_d[slot] = i;
            end else begin
              neg_d[slot] = i;
              count_d     = count_q + CNT_W'(1);
            end
          end
        end else if (state_q == LOAD) begin
          // An unpaired positive word never bumped the count, so it is dropped.
          state_d = SEARCH;
          half_d  = 1'b0;
        end
      end
      SEARCH: begin
        if (conflict) begin
          if (depth_q == '0) begin
            state_d = DONE;
            ended_d = 1'b1;
            sat_d   = 1'b0;
            model_d = '0;
          end else begin
            state_d = BACKTRACK;
          end
        end else if (depth_q == DEPTH_W'(number_literal)) begin
          state_d = DONE;
          ended_d = 1'b1;
          sat_d   = 1'b1;
          model_d = value_q;
        end else begin
          assigned_d[next_bit] = 1'b1;
          value_d[next_bit]    = 1'b0;
          tried1_d[next_bit]   = 1'b0;
          depth_d              = depth_q + DEPTH_W'(1);
        end
      end
      BACKTRACK: begin
        if (!tried1_q[last_bit]) begin
          value_d[last_bit]  = 1'b1;
          tried1_d[last_bit] = 1'b1;
          state_d            = SEARCH;
        end else begin
          assigned_d[last_bit] = 1'b0;
          value_d[last_bit]    = 1'b0;
          tried1_d[last_bit]   = 1'b0;
          depth_d              = depth_q - DEPTH_W'(1);
          if (depth_q == DEPTH_W'(1)) begin
            state_d = DONE;
            ended_d = 1'b1;
            sat_d   = 1'b0;
            model_d = '0;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_q      <= '{default: '0};
      neg_q      <= '{default: '0};
      count_q    <= '0;
      half_q     <= 1'b0;
      assigned_q <= '0;
      value_q    <= '0;
      tried1_q   <= '0;
      depth_q    <= '0;
      ended_q    <= 1'b0;
      sat_q      <= 1'b0;
      model_q    <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      count_q    <= count_d;
      half_q     <= half_d;
      assigned_q <= assigned_d;
      value_q    <= value_d;
      tried1_q   <= tried1_d;
      depth_q    <= depth_d;
      ended_q    <= ended_d;
      sat_q      <= sat_d;
      model_q    <= model_d;
    end
  end

  assign ended = ended_q;
  assign sat   = sat_q;
  assign model = model_q;
endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the SAT solver: directed instances plus random 8-variable
// formulas checked against a brute-force lexicographic reference.
module tb_top;
  import common::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [29:0] i;
  logic        ended;
  logic        sat;
  logic [29:0] model;

  top dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .i     (i),
    .ended (ended),
    .sat   (sat),
    .model (model)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sat;
    logic [29:0] model;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [29:0] cp[$];
  logic [29:0] cn[$];
  bit          trail;
  logic [29:0] trail_word;
  logic        ended_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] L(input int k);
    L = 30'(1) << (29 - k);
  endfunction

  task automatic add(input logic [29:0] p, input logic [29:0] n);
    cp.push_back(p);
    cn.push_back(n);
  endtask

  task automatic push_exp(input logic s, input logic [29:0] m);
    exp_t e;
    e.sat   = s;
    e.model = m;
    sb.push_back(e);
  endtask

  // Only variables 0..7 may appear; the rest stay 0 in any minimal model.
  function automatic exp_t ref_solve();
    exp_t r;
    int   n;
    n = (cp.size() > number_clause) ? number_clause : cp.size();
    r.sat   = 1'b0;
    r.model = '0;
    for (int a = 0; a < 256; a++) begin
      logic [29:0] m;
      bit          ok;
      m  = 30'(a) << 22;
      ok = 1'b1;
      for (int c = 0; c < n; c++)
        if (((cp[c] & m) == '0) && ((cn[c] & ~m) == '0)) ok = 1'b0;
      if (ok) begin
        r.sat   = 1'b1;
        r.model = m;
        return r;
      end
    end
    return r;
  endfunction

  task automatic push_ref();
    exp_t r;
    r = ref_solve();
    sb.push_back(r);
  endtask

  always @(negedge clock) begin
    if (!reset && ended && !ended_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: sat=%0b model=%0h with nothing expected", sat, model);
      end else begin
        mon_e = sb.pop_front();
        chk("result_sat", 64'(sat), 64'(mon_e.sat));
        chk("result_model", 64'(model), 64'(mon_e.model));
      end
    end
    ended_prev <= ended;
  end

  task automatic send_words();
    for (int c = 0; c < cp.size(); c++) begin
      load = 1'b1;
      i    = cp[c];
      @(negedge clock);
      i    = cn[c];
      @(negedge clock);
    end
    if (trail) begin
      load = 1'b1;
      i    = trail_word;
      @(negedge clock);
    end
    load = 1'b0;
    i    = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clock);
      lat++;
      if (ended) break;
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL timeout: ended=%0b after %0d cycles, required 1", ended, lat);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_ended"}, 64'(ended), 64'd0);
    chk({tag, "_sat"}, 64'(sat), 64'd0);
    chk({tag, "_model"}, 64'(model), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    cp.delete();
    cn.delete();
    trail = 1'b0;
    @(negedge clock);
  endtask

  task automatic build_chain();
    int base;
    int nb;
    for (int b = 0; b < 5; b++) begin
      base = 6 * b;
      add(L(base + 3), L(base) | L(base + 1));
      add(L(base), L(base + 3));
      add(L(base + 1), L(base + 3));
      add(L(base + 3) | L(base + 4), '0);
      add('0, L(base + 3) | L(base + 4));
      add(L(base + 2) | L(base + 5), '0);
      add('0, L(base + 2) | L(base + 5));
      if (b < 4) begin
        nb = base + 6;
        add(L(nb + 1), L(base + 4));
        add(L(base + 4), L(nb + 1));
        add(L(nb + 2), L(base + 5));
        add(L(base + 5), L(nb + 2));
      end
    end
    add('0, L(1));
    add('0, L(2));
    add(L(28), '0);
    add(L(29), '0);
  endtask

  localparam logic [29:0] CHAIN_MODEL = 30'b000011_011010_010011_011010_010011;

  initial begin
    int lat;
    int nc;
    int r;
    logic [29:0] p;
    logic [29:0] n;
    logic [29:0] held;

    reset = 1'b1;
    load  = 1'b0;
    i     = '0;
    trail = 1'b0;
    trail_word = '0;
    #1;
    chk("reset_ended", 64'(ended), 64'd0);
    chk("reset_sat", 64'(sat), 64'd0);
    chk("reset_model", 64'(model), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    build_chain();
    chk("chain_count", 64'(cp.size()), 64'd55);
    push_exp(1'b1, CHAIN_MODEL);
    send_words();
    wait_done(lat);
    do_reset("after_chain");

    add(L(0), '0);
    add('0, L(0));
    push_exp(1'b0, '0);
    send_words();
    wait_done(lat);
    do_reset("after_contra");

    add('0, '0);
    push_exp(1'b0, '0);
    send_words();
    wait_done(lat);
    chk("empty_clause_latency", 64'(lat), 64'd2);
    do_reset("after_empty");

    trail      = 1'b1;
    trail_word = 30'h2AAA_AAAA;
    push_exp(1'b1, '0);
    send_words();
    wait_done(lat);
    chk("no_clause_latency", 64'(lat), 64'd32);
    do_reset("after_noclause");

    add('0, L(0) | L(1));
    add(L(1), '0);
    push_exp(1'b1, 30'h1000_0000);
    send_words();
    wait_done(lat);
    held = model;
    for (int k = 0; k < 3; k++) begin
      load = 1'b1;
      i    = '1;
      @(negedge clock);
    end
    load = 1'b0;
    i    = '0;
    @(negedge clock);
    chk("done_ignores_load_ended", 64'(ended), 64'd1);
    chk("done_ignores_load_model", 64'(model), 64'(held));
    do_reset("after_unit");

    build_chain();
    send_words();
    repeat (10) @(negedge clock);
    chk("mid_search_ended", 64'(ended), 64'd0);
    do_reset("mid_search");
    build_chain();
    push_exp(1'b1, CHAIN_MODEL);
    send_words();
    wait_done(lat);
    do_reset("after_reload");

    for (int c = 0; c < number_clause; c++) add(L(0), L(0));
    for (int c = 0; c < 3; c++) add('0, '0);
    push_ref();
    send_words();
    wait_done(lat);
    do_reset("after_capacity");

    add(L(0), '0);
    trail      = 1'b1;
    trail_word = '0;
    push_ref();
    send_words();
    wait_done(lat);
    do_reset("after_trail");

    for (int t = 0; t < 8; t++) begin
      nc = int'($urandom_range(1, 24));
      for (int c = 0; c < nc; c++) begin
        p = '0;
        n = '0;
        for (int v = 0; v < 8; v++) begin
          r = int'($urandom_range(0, 5));
          if (r == 0) p = p | L(v);
          else if (r == 1) n = n | L(v);
        end
        add(p, n);
      end
      trail      = ($urandom_range(0, 3) == 0);
      trail_word = 30'($urandom);
      push_ref();
      send_words();
      wait_done(lat);
      do_reset("after_random");
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d results never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
